// File: rtl/multicycle_main_decoder_pkg.sv
// Shared types and encodings for the multicycle main decoder.
// The POST_INDEX_EN macro adds the WBBASE state (post-indexed base writeback).
package controller_pkg;

    // Controller states; WBBASE exists only when post-indexing is built in
    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWR,
        MEMWB,
`ifdef POST_INDEX_EN
        WBBASE,
`endif
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    // Instruction class, instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Immediate extender format
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    // One cycle's worth of datapath controls
    typedef struct packed {
        logic       mem_req;
        logic       mem_w;
        logic       ir_w;
        logic       pc_w;
        logic       branch;
        logic       reg_w;
        logic       base_w;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic       alu_op;
        logic       post_idx;
        logic       bus_err;
        logic       illegal;
    } ctrl_t;

    // States that hold a memory request open and may stall on mem_ready
    function automatic logic waits_on_bus(state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

    // Memory offset operand: funct[5] is I-bar, so 1 selects a register offset
    function automatic logic [1:0] offset_src_b(logic not_imm);
        return not_imm ? SRCB_REG : SRCB_IMM;
    endfunction

endpackage

// File: rtl/multicycle_main_decoder_if.sv
// Memory request/ready handshake between the main decoder and the memory.
interface multicycle_main_decoder_if;
    logic mem_req;
    logic mem_w;
    logic mem_ready;

    // Decoder side: issues requests, sees completion
    modport master (output mem_req, output mem_w, input mem_ready);
    // Memory side: sees requests, signals completion
    modport slave  (input mem_req, input mem_w, output mem_ready);
endinterface

// File: rtl/multicycle_main_decoder_wait_timer.sv
// Memory wait-state counter with timeout detection.
// expired is high in the wait cycle where the count reaches MEM_TIMEOUT-1;
// MEM_TIMEOUT = 0 disables it.
module wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    // A zero-width counter is illegal, so keep at least one bit
    localparam int CW = (CNT_W > 0) ? CNT_W : 1;
    localparam logic [CW-1:0] LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt;

    assign expired = (MEM_TIMEOUT != 0) && en && (cnt == LAST);

    // Count consecutive wait cycles; restart on completion, state change or abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || !en || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_main_decoder.sv
// Main control FSM of the multicycle ARM core: sequences fetch, decode,
// execute, memory and writeback, with a memory wait/timeout handshake.
// Define POST_INDEX_EN to decode post-indexed accesses and add WBBASE.
module multicycle_main_decoder
    import controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [1:0]                       op,
    input  logic [5:0]                       funct,
    multicycle_main_decoder_if.master        bus,
    output logic                             ir_w,
    output logic                             pc_w,
    output logic                             branch,
    output logic                             reg_w,
    output logic                             base_w,
    output logic                             adr_src,
    output logic [1:0]                       alu_src_a,
    output logic [1:0]                       alu_src_b,
    output logic [1:0]                       result_src,
    output logic [1:0]                       imm_src,
    output logic                             alu_op,
    output logic                             post_idx,
    output logic                             bus_err,
    output logic                             illegal
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    ctrl_t  ctrl_o;
    logic   expired;
    logic   timer_en;
    logic   timer_clr;

`ifdef POST_INDEX_EN
    // Post-index flag captured in MEMADR, held through memory and writeback
    logic   post_idx_q;
`endif

    // funct[3:1] (and funct[4] without post-indexing) carry no control meaning here
    logic unused_funct;
    assign unused_funct = ^funct[4:1];

    assign timer_en  = waits_on_bus(state) && !bus.mem_ready;
    assign timer_clr = (state_next != state);

    wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    // State register and post-index capture
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking (<=) for every flop so all of them sample pre-edge values.
        if (!reset) begin
            state      <= FETCH;
`ifdef POST_INDEX_EN
            post_idx_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
`ifdef POST_INDEX_EN
            if (state == MEMADR) begin
                post_idx_q <= ~funct[4];
            end
`endif
        end
    end

    // Next state and per-state controls; only ir_w/pc_w, mem_w and bus_err see mem_ready
    always_comb begin
        // NOTE: defaults first so every path assigns every signal; otherwise latches appear.
        ctrl       = '0;
        state_next = state;
        case (state)
            FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
                if (bus.mem_ready) begin
                    ctrl.ir_w  = 1'b1;
                    ctrl.pc_w  = 1'b1;
                    state_next = DECODE;
                end else if (expired) begin
                    ctrl.bus_err = 1'b1;
                end
            end
            DECODE: begin
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
                case (op)
                    OP_DP:   state_next = funct[5] ? EXECI : EXECR;
                    OP_MEM:  state_next = MEMADR;
                    OP_BR:   state_next = BRANCH;
                    default: begin
                        ctrl.illegal = 1'b1;
                        state_next   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = offset_src_b(funct[5]);
                ctrl.imm_src   = IMM_MEM;
`ifdef POST_INDEX_EN
                ctrl.post_idx  = ~funct[4];
`endif
                state_next     = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
`ifdef POST_INDEX_EN
                ctrl.post_idx = post_idx_q;
`endif
                if (bus.mem_ready) begin
                    state_next = MEMWB;
                end else if (expired) begin
                    ctrl.bus_err = 1'b1;
                    state_next   = FETCH;
                end
            end
            MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
                ctrl.mem_w   = 1'b1;
`ifdef POST_INDEX_EN
                ctrl.post_idx = post_idx_q;
`endif
                if (bus.mem_ready) begin
`ifdef POST_INDEX_EN
                    state_next = post_idx_q ? WBBASE : FETCH;
`else
                    state_next = FETCH;
`endif
                end else if (expired) begin
                    ctrl.mem_w   = 1'b0;
                    ctrl.bus_err = 1'b1;
                    state_next   = FETCH;
                end
            end
            MEMWB: begin
                ctrl.reg_w      = 1'b1;
                ctrl.result_src = RES_RDATA;
`ifdef POST_INDEX_EN
                ctrl.post_idx   = post_idx_q;
                state_next      = post_idx_q ? WBBASE : FETCH;
`else
                state_next      = FETCH;
`endif
            end
`ifdef POST_INDEX_EN
            WBBASE: begin
                ctrl.reg_w      = 1'b1;
                ctrl.base_w     = 1'b1;
                ctrl.alu_src_a  = SRCA_REG;
                ctrl.alu_src_b  = offset_src_b(funct[5]);
                ctrl.result_src = RES_ALU;
                ctrl.post_idx   = post_idx_q;
                state_next      = FETCH;
            end
`endif
            EXECR: begin
                ctrl.alu_op    = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.imm_src   = IMM_DP;
                state_next     = ALUWB;
            end
            EXECI: begin
                ctrl.alu_op    = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = IMM_DP;
                state_next     = ALUWB;
            end
            ALUWB: begin
                ctrl.reg_w      = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                state_next      = FETCH;
            end
            BRANCH: begin
                ctrl.branch     = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.imm_src    = IMM_BR;
                ctrl.result_src = RES_ALU;
                state_next      = FETCH;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Every output is held low while reset is asserted
    assign ctrl_o = reset ? ctrl : '0;

    assign bus.mem_req = ctrl_o.mem_req;
    assign bus.mem_w   = ctrl_o.mem_w;
    assign ir_w        = ctrl_o.ir_w;
    assign pc_w        = ctrl_o.pc_w;
    assign branch      = ctrl_o.branch;
    assign reg_w       = ctrl_o.reg_w;
    assign base_w      = ctrl_o.base_w;
    assign adr_src     = ctrl_o.adr_src;
    assign alu_src_a   = ctrl_o.alu_src_a;
    assign alu_src_b   = ctrl_o.alu_src_b;
    assign result_src  = ctrl_o.result_src;
    assign imm_src     = ctrl_o.imm_src;
    assign alu_op      = ctrl_o.alu_op;
    assign post_idx    = ctrl_o.post_idx;
    assign bus_err     = ctrl_o.bus_err;
    assign illegal     = ctrl_o.illegal;

endmodule

// File: doc/multicycle_main_decoder.md
# multicycle_main_decoder

Main control FSM for the multicycle ARM core. It replaces the single-cycle combinational main decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the per-cycle datapath selects and write enables. It also adds a `mem_req`/`mem_ready` handshake with wait states, a bus timeout, and a post-indexed base writeback state. It sits in the controller, ahead of the ALU decoder and the condition logic; the condition logic gates `reg_w`, `mem_w`, `pc_w` and `branch`.

## Interface
- `MEM_TIMEOUT`, default 16: consecutive not-ready cycles in a memory state before abort; 0 disables the timeout.
- `CNT_W`, default `$clog2(MEM_TIMEOUT+1)`: width of the wait counter.
- `clk`  input  1  clock.
- `reset`  input  1  reset; **one clock; reset is asynchronous and active-low**.
- `op`  input  2  instr[27:26].
- `funct`  input  6  instr[25:20]: [5]=I̅ for memory / I for DP, [4]=P, [0]=L.
- `mem_ready`  input  1  memory completes the current request this cycle.
- `mem_req`  output  1  memory access request.
- `mem_w`  output  1  store enable.
- `ir_w`  output  1  instruction register write.
- `pc_w`  output  1  PC update (fetch).
- `branch`  output  1  branch PC update.
- `reg_w`  output  1  register file write.
- `base_w`  output  1  marks a base-register writeback (write address is Rn).
- `adr_src`  output  1  0=PC, 1=ALU result/base.
- `alu_src_a`  output  2  00=reg, 01=PC.
- `alu_src_b`  output  2  00=reg, 01=ext imm, 10=const 4.
- `result_src`  output  2  00=ALU out reg, 01=read data, 10=ALU result.
- `imm_src`  output  2  00=DP, 01=memory, 10=branch.
- `alu_op`  output  1  ALU decoder takes funct; 0 forces add.
- `post_idx`  output  1  memory address is the base, not base±offset.
- `bus_err`  output  1  one-cycle pulse on timeout abort.
- `illegal`  output  1  one-cycle pulse in DECODE for op=11.

## Operation
States:
- **FETCH**:
  - Controls: `mem_req`=1, `adr_src`=0, `alu_src_a`=01, `alu_src_b`=10, `result_src`=10.
  - `ir_w` and `pc_w` are asserted only in the cycle `mem_ready`=1; that cycle moves to DECODE. Otherwise the FSM holds in FETCH.
- **DECODE**:
  - Controls: `alu_src_a`=01, `alu_src_b`=10, `result_src`=10 (PC+8).
  - Next state: op=00 → EXECR if funct[5]=0, EXECI if funct[5]=1. op=01 → MEMADR. op=10 → BRANCH. op=11 → FETCH with `illegal`=1.
- **MEMADR**:
  - Controls: `alu_src_a`=00, `alu_src_b`=01 if funct[5]=0 else 00, `imm_src`=01.
  - `post_idx` = ~funct[4]; it is held through the memory and writeback states.
  - Next state: MEMRD if funct[0]=1, else MEMWR.
- **MEMRD**: `mem_req`=1, `adr_src`=1. On `mem_ready` → MEMWB.
- **MEMWR**: `mem_req`=1, `adr_src`=1, `mem_w`=1. On `mem_ready` → WBBASE if `post_idx`, else FETCH.
- **MEMWB**: `reg_w`=1, `result_src`=01. Then WBBASE if `post_idx`, else FETCH.
- **WBBASE**:
  - Controls: `reg_w`=1, `base_w`=1, `alu_src_a`=00, `alu_src_b` as in MEMADR, `result_src`=10.
  - Next state: FETCH.
- **EXECR / EXECI**: `alu_op`=1; `alu_src_b`=00 (EXECR) or 01 (EXECI); `imm_src`=00. Next state: ALUWB.
- **ALUWB**: `reg_w`=1, `result_src`=00. Next state: FETCH.
- **BRANCH**: `branch`=1, `alu_src_a`=01, `alu_src_b`=01, `imm_src`=10, `result_src`=10. Next state: FETCH.

Output rules:
- All unlisted outputs are 0 in every state.
- Outputs are Moore outputs of the state, except `ir_w`/`pc_w`, which are qualified by `mem_ready`.
- Timeout:
  - The wait counter increments each cycle in FETCH, MEMRD or MEMWR while `mem_ready`=0. It clears on any state change or on `mem_ready`=1.
  - When the counter reaches `MEM_TIMEOUT`-1 with `mem_ready`=0, that cycle asserts `bus_err`=1, suppresses `mem_w`, `ir_w` and `pc_w`, and moves to FETCH.
  - No register or base write follows an abort.

## Timing
- State register and wait counter update on `posedge clk`; both reset asynchronously on `negedge reset`.
- While `reset`=0, every output is forced to 0. The state is FETCH and the counter is 0.
- After reset release, FETCH controls are driven in the same cycle.
- Latency with zero wait states:
  - DP: 4 cycles.
  - Branch: 3 cycles.
  - STR: 4 cycles; STR post-index: 5.
  - LDR: 5 cycles; LDR post-index: 6.
- Each wait cycle adds 1.
- `mem_ready` sampled outside FETCH/MEMRD/MEMWR is ignored.
- A `mem_ready` that coincides with the timeout cycle wins: the access completes normally and `bus_err` stays 0.

## Configuration
- `POST_INDEX_EN` defined: `post_idx` is decoded and the WBBASE state exists.
- `POST_INDEX_EN` undefined: `post_idx` and `base_w` are tied to 0, and WBBASE is absent. P=0 accesses are treated as offset accesses: MEMWR and MEMWB always go to FETCH.

## Structure
- Package `controller_pkg` holds:
  - the `state_t` enum;
  - the `alu_src_a`, `alu_src_b`, `result_src` and `imm_src` encoding constants;
  - the `op` encodings (DP=00, MEM=01, BR=10).
- Sub-module `wait_timer` contains the counter, its clear/enable inputs, the `MEM_TIMEOUT` compare and the `expired` output.

## Test plan
- DP reg: op=00, funct=000000, `mem_ready`=1 → FETCH, DECODE, EXECR, ALUWB, FETCH. `reg_w`=1 and `alu_op`=0 in ALUWB only; `alu_op`=1 in EXECR.
- LDR imm with waits: op=01, funct=011001, `mem_ready`=0 for 2 cycles in MEMRD → 7 cycles total. MEMWB drives `reg_w`=1, `result_src`=01, `post_idx`=0.
- STR reg post-index: op=01, funct=101000 → MEMWR drives `mem_w`=1, `adr_src`=1, `post_idx`=1. WBBASE follows with `reg_w`=1, `base_w`=1, `alu_src_b`=00. Without `POST_INDEX_EN`, WBBASE is absent and `post_idx`=0.
- Branch: op=10 → 3 cycles. BRANCH drives `branch`=1, `imm_src`=10, `alu_src_b`=01.
- Timeout: `MEM_TIMEOUT`=4, `mem_ready`=0 in FETCH → `bus_err`=1 on the 4th wait cycle, `ir_w` never asserted, FETCH re-entered with the counter at 0.
- Reset mid-MEMWR: `reset`=0 while `mem_w`=1 → all outputs 0 immediately. After release the state is FETCH and there is no `mem_w` and no `reg_w`.
